// File: rtl/multicycle_controller.sv
// Control unit for the multicycle RV32I core: Moore FSM, instruction decoder and ALU decoder.
// Memory accesses stretch on mem_ready; undecodable instructions park in a sticky ILLEGAL state.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] immsrc,
  output logic [3:0] alucontrol,
  output logic       illegal
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_LINK     = 4'd12;
  localparam logic [3:0] S_UPPER    = 4'd13;
  localparam logic [3:0] S_ILLEGAL  = 4'd14;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  logic [3:0] state_q, state_d;
  logic [3:0] alu_dec;
  logic       branch_taken;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: each combinational output is defaulted first so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = (funct3 == 3'b010) ? S_MEMADR : S_ILLEGAL;
          OP_R:              state_d = S_EXECUTER;
          OP_I:              state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = (funct3[2:1] == 2'b01) ? S_ILLEGAL : S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = (funct3 == 3'b000) ? S_JALR : S_ILLEGAL;
          OP_LUI, OP_AUIPC:  state_d = S_UPPER;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_MEMWB, S_ALUWB, S_BRANCH:                  state_d = S_FETCH;
      S_EXECUTER, S_EXECUTEI, S_JAL, S_LINK, S_UPPER: state_d = S_ALUWB;
      S_JALR:     state_d = S_LINK;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  // Immediate-ALU instructions have no subi, so funct7b5 only matters for shifts there.
  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (funct7b5 && state_q == S_EXECUTER) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  end

  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = !zero;
      3'b100:  branch_taken = lt;
      3'b101:  branch_taken = !lt;
      3'b110:  branch_taken = ltu;
      3'b111:  branch_taken = !ltu;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    immsrc = 3'b000;
    case (op)
      OP_STORE:         immsrc = 3'b001;
      OP_BRANCH:        immsrc = 3'b010;
      OP_LUI, OP_AUIPC: immsrc = 3'b011;
      OP_JAL:           immsrc = 3'b100;
      default:          immsrc = 3'b000;
    endcase
  end

  always_comb begin
    pcwrite    = 1'b0;
    adrsrc     = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    resultsrc  = 2'b00;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    alucontrol = ALU_ADD;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwrite   = mem_ready;
        pcwrite   = mem_ready;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      S_MEMREAD: adrsrc = 1'b1;
      S_MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTER: begin
        alusrca    = 2'b10;
        alucontrol = alu_dec;
      end
      S_EXECUTEI: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        alucontrol = alu_dec;
      end
      S_ALUWB: regwrite = 1'b1;
      S_BRANCH: begin
        alusrca    = 2'b10;
        alucontrol = ALU_SUB;
        pcwrite    = branch_taken;
      end
      S_JAL: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
        pcwrite = 1'b1;
      end
      S_JALR: begin
        alusrca   = 2'b10;
        alusrcb   = 2'b01;
        resultsrc = 2'b10;
        pcwrite   = 1'b1;
      end
      S_LINK: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
      end
      S_UPPER: begin
        alusrca = (op == OP_LUI) ? 2'b11 : 2'b01;
        alusrcb = 2'b01;
      end
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
    // Reset shows FETCH selects but must never let a write strobe escape.
    if (!rst_n) begin
      pcwrite  = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction step-list model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_multicycle_controller;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, lt, ltu, mem_ready;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb;
  logic [2:0] immsrc;
  logic [3:0] alucontrol;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .adrsrc(adrsrc), .memwrite(memwrite), .irwrite(irwrite),
    .regwrite(regwrite), .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .immsrc(immsrc), .alucontrol(alucontrol), .illegal(illegal)
  );

  typedef struct packed {
    logic       pcwrite, adrsrc, memwrite, irwrite, regwrite;
    logic [1:0] resultsrc, alusrca, alusrcb;
    logic [2:0] immsrc;
    logic [3:0] alucontrol;
    logic       illegal;
  } outs_t;

  typedef enum {P_FETCH, P_DECODE, P_ADDR, P_RD, P_RDWB, P_WR, P_ALU_R, P_ALU_I,
                P_WB, P_BR, P_JAL, P_JALR, P_LINK, P_UP, P_TRAP} step_t;

  outs_t act;
  assign act = {pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc, alusrca,
                alusrcb, immsrc, alucontrol, illegal};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  step_t cur;
  step_t pend[$];

  // After DECODE, each instruction is a fixed list of steps ending back in FETCH.
  function automatic void plan_steps();
    pend.delete();
    case (op)
      OP_LOAD:   if (funct3 == 3'b010) begin pend.push_back(P_ADDR); pend.push_back(P_RD); pend.push_back(P_RDWB); end
                 else pend.push_back(P_TRAP);
      OP_STORE:  if (funct3 == 3'b010) begin pend.push_back(P_ADDR); pend.push_back(P_WR); end
                 else pend.push_back(P_TRAP);
      OP_R:      begin pend.push_back(P_ALU_R); pend.push_back(P_WB); end
      OP_I:      begin pend.push_back(P_ALU_I); pend.push_back(P_WB); end
      OP_BRANCH: if (funct3 == 3'b010 || funct3 == 3'b011) pend.push_back(P_TRAP);
                 else pend.push_back(P_BR);
      OP_JAL:    begin pend.push_back(P_JAL); pend.push_back(P_WB); end
      OP_JALR:   if (funct3 == 3'b000) begin pend.push_back(P_JALR); pend.push_back(P_LINK); pend.push_back(P_WB); end
                 else pend.push_back(P_TRAP);
      OP_LUI, OP_AUIPC: begin pend.push_back(P_UP); pend.push_back(P_WB); end
      default:   pend.push_back(P_TRAP);
    endcase
  endfunction

  task automatic take_next();
    if (pend.size() == 0) cur = P_FETCH;
    else cur = pend.pop_front();
  endtask

  initial begin
    cur = P_FETCH;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cur = P_FETCH;
        pend.delete();
      end else begin
        case (cur)
          P_TRAP:     ;
          P_FETCH:    if (mem_ready) cur = P_DECODE;
          P_DECODE:   begin plan_steps(); take_next(); end
          P_RD, P_WR: if (mem_ready) take_next();
          default:    take_next();
        endcase
      end
    end
  end

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      OP_LOAD, OP_I, OP_JALR: return 3'b000;
      OP_STORE:               return 3'b001;
      OP_BRANCH:              return 3'b010;
      OP_LUI, OP_AUIPC:       return 3'b011;
      OP_JAL:                 return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic b5, input logic is_reg);
    case (f3)
      3'b000:  return (is_reg && b5) ? 4'b0001 : 4'b0000;
      3'b001:  return 4'b0101;
      3'b010:  return 4'b1000;
      3'b011:  return 4'b1001;
      3'b100:  return 4'b0100;
      3'b101:  return b5 ? 4'b0111 : 4'b0110;
      3'b110:  return 4'b0011;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic taken_of(input logic [2:0] f3);
    case (f3)
      3'b000:  return zero;
      3'b001:  return !zero;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic outs_t expect_now();
    outs_t e;
    e = '0;
    e.immsrc = imm_of(op);
    case (cur)
      P_FETCH:  begin e.irwrite = mem_ready; e.pcwrite = mem_ready; e.alusrcb = 2'b10; e.resultsrc = 2'b10; end
      P_DECODE: begin e.alusrca = 2'b01; e.alusrcb = 2'b01; end
      P_ADDR:   begin e.alusrca = 2'b10; e.alusrcb = 2'b01; end
      P_RD:     e.adrsrc = 1'b1;
      P_RDWB:   begin e.resultsrc = 2'b01; e.regwrite = 1'b1; end
      P_WR:     begin e.adrsrc = 1'b1; e.memwrite = 1'b1; end
      P_ALU_R:  begin e.alusrca = 2'b10; e.alucontrol = alu_of(funct3, funct7b5, 1'b1); end
      P_ALU_I:  begin e.alusrca = 2'b10; e.alusrcb = 2'b01; e.alucontrol = alu_of(funct3, funct7b5, 1'b0); end
      P_WB:     e.regwrite = 1'b1;
      P_BR:     begin e.alusrca = 2'b10; e.alucontrol = 4'b0001; e.pcwrite = taken_of(funct3); end
      P_JAL:    begin e.alusrca = 2'b01; e.alusrcb = 2'b10; e.pcwrite = 1'b1; end
      P_JALR:   begin e.alusrca = 2'b10; e.alusrcb = 2'b01; e.resultsrc = 2'b10; e.pcwrite = 1'b1; end
      P_LINK:   begin e.alusrca = 2'b01; e.alusrcb = 2'b10; end
      P_UP:     begin e.alusrcb = 2'b01; e.alusrca = (op == OP_LUI) ? 2'b11 : 2'b01; end
      P_TRAP:   e.illegal = 1'b1;
      default:  ;
    endcase
    if (!rst_n) begin
      e.pcwrite = 1'b0; e.irwrite = 1'b0; e.regwrite = 1'b0; e.memwrite = 1'b0;
    end
    return e;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      check($sformatf("cycle_%s", cur.name()), 32'(act), 32'(expect_now()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [6:0] o, input logic [2:0] f3, input logic b5);
    op = o; funct3 = f3; funct7b5 = b5;
  endtask

  task automatic run(input string name, input logic [6:0] o, input logic [2:0] f3,
                     input logic b5, input int lat);
    int n;
    n = 0;
    load(o, f3, b5);
    do begin cyc(); n++; end while (cur != P_FETCH && n < 40);
    check({name, "_latency"}, 32'(n), 32'(lat));
    #1 check({name, "_refetch"}, 32'(irwrite), 1);
  endtask

  logic [6:0] bad_op [7] = '{7'b1111111, OP_LOAD, OP_STORE, OP_BRANCH, OP_BRANCH, OP_JALR, 7'b0000000};
  logic [2:0] bad_f3 [7] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b011, 3'b001, 3'b000};
  logic [2:0] br_f3  [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;
    #2;
    check("rst_irwrite", 32'(irwrite), 0);
    check("rst_pcwrite", 32'(pcwrite), 0);
    check("rst_alusrcb", 32'(alusrcb), 32'b10);
    check("rst_illegal", 32'(illegal), 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // add, then sub
    load(OP_R, 3'b000, 1'b0);
    #2 check("add_fetch_irwrite", 32'(irwrite), 1);
    cyc(); #2 check("add_decode_alusrca", 32'(alusrca), 32'b01);
    cyc(); #2 check("add_exec_alu", 32'(alucontrol), 32'b0000);
    cyc(); #2 check("add_wb_regwrite", 32'(regwrite), 1);
    cyc(); #2 check("add_back_fetch", 32'(irwrite), 1);
    load(OP_R, 3'b000, 1'b1);
    cyc(); cyc(); #2 check("sub_exec_alu", 32'(alucontrol), 32'b0001);
    cyc(); cyc();

    // fetch stall
    mem_ready = 1'b0;
    #2 check("fetch_stall_irwrite", 32'(irwrite), 0);
    cyc(); mem_ready = 1'b1;

    // lw with two wait cycles in MEMREAD
    load(OP_LOAD, 3'b010, 1'b0);
    cyc(); cyc(); cyc(); mem_ready = 1'b0;
    #2 check("lw_rd0_adrsrc", 32'(adrsrc), 1);
    cyc(); #2 check("lw_rd1_adrsrc", 32'(adrsrc), 1);
    cyc(); mem_ready = 1'b1;
    #2 check("lw_rd2_adrsrc", 32'(adrsrc), 1);
    cyc(); #2 check("lw_wb_resultsrc", 32'(resultsrc), 32'b01);
    check("lw_wb_regwrite", 32'(regwrite), 1);
    cyc();

    // bge not taken / taken
    load(OP_BRANCH, 3'b101, 1'b0); lt = 1'b0;
    cyc(); cyc(); #2 check("bge_taken_pcwrite", 32'(pcwrite), 1);
    check("bge_immsrc", 32'(immsrc), 32'b010);
    cyc();
    lt = 1'b1;
    cyc(); cyc(); #2 check("bge_not_taken_pcwrite", 32'(pcwrite), 0);
    cyc(); lt = 1'b0;

    // jalr
    load(OP_JALR, 3'b000, 1'b0);
    #2 check("jalr_fetch_immsrc", 32'(immsrc), 32'b000);
    cyc(); cyc(); #2 check("jalr_pcwrite", 32'(pcwrite), 1);
    check("jalr_resultsrc", 32'(resultsrc), 32'b10);
    check("jalr_immsrc", 32'(immsrc), 32'b000);
    cyc(); #2 check("link_alusrca", 32'(alusrca), 32'b01);
    check("link_alusrcb", 32'(alusrcb), 32'b10);
    cyc(); #2 check("jalr_wb_regwrite", 32'(regwrite), 1);
    cyc();

    // model-checked sweep with hand-computed latencies
    run("sw", OP_STORE, 3'b010, 1'b0, 4);
    run("jal", OP_JAL, 3'b000, 1'b0, 4);
    run("lui", OP_LUI, 3'b000, 1'b0, 4);
    run("auipc", OP_AUIPC, 3'b111, 1'b0, 4);
    run("lw", OP_LOAD, 3'b010, 1'b0, 5);
    run("jalr", OP_JALR, 3'b000, 1'b0, 5);
    for (int f = 0; f < 8; f++) begin
      for (int b = 0; b < 2; b++) begin
        run($sformatf("r_f%0d_b%0d", f, b), OP_R, 3'(f), 1'(b), 4);
        run($sformatf("i_f%0d_b%0d", f, b), OP_I, 3'(f), 1'(b), 4);
      end
    end
    for (int k = 0; k < 6; k++) begin
      for (int fl = 0; fl < 8; fl++) begin
        zero = fl[0]; lt = fl[1]; ltu = fl[2];
        run($sformatf("br_f%0d_fl%0d", br_f3[k], fl), OP_BRANCH, br_f3[k], 1'b0, 3);
      end
    end

    // sw stalled in MEMWRITE, then reset mid-access
    load(OP_STORE, 3'b010, 1'b0);
    cyc(); cyc(); cyc(); mem_ready = 1'b0;
    #2 check("sw_wait0_memwrite", 32'(memwrite), 1);
    cyc(); #2 check("sw_wait1_memwrite", 32'(memwrite), 1);
    rst_n = 1'b0; mem_ready = 1'b1;
    #1 check("rst_mid_memwrite", 32'(memwrite), 0);
    check("rst_mid_irwrite", 32'(irwrite), 0);
    check("rst_mid_alusrcb", 32'(alusrcb), 32'b10);
    cyc(); cyc(); rst_n = 1'b1;
    #1 check("post_rst_irwrite", 32'(irwrite), 1);

    // illegal encodings: sticky until reset
    for (int k = 0; k < 7; k++) begin
      load(bad_op[k], bad_f3[k], 1'b0);
      cyc(); cyc();
      for (int c = 0; c < 12; c++) begin
        mem_ready = 1'(c % 2);
        cyc();
      end
      #1 check($sformatf("illegal_%0d_sticky", k), 32'(illegal), 1);
      check($sformatf("illegal_%0d_strobes", k),
            32'({pcwrite, irwrite, regwrite, memwrite}), 0);
      mem_ready = 1'b1;
      rst_n = 1'b0;
      #1 check($sformatf("illegal_%0d_cleared", k), 32'(illegal), 0);
      cyc(); rst_n = 1'b1;
    end
    run("after_illegal_add", OP_R, 3'b000, 1'b0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle RV32I core; sits directly upstream of the immediate extender and drives `immsrc`, ALU control, datapath mux selects and register/memory write strobes. It consists of a Moore state machine, a combinational instruction decoder and ALU decoder. A memory-ready handshake stretches fetch/load/store states. Undecodable instructions trap to a sticky illegal state.

## Interface
- No parameters.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `op` in 7: instr[6:0] from the instruction register.
- `funct3` in 3: instr[14:12].
- `funct7b5` in 1: instr[30].
- `zero`, `lt`, `ltu` in 1 each: ALU flags (result==0, signed <, unsigned <), valid combinationally during BRANCH.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pcwrite` out 1: PC register enable.
- `adrsrc` out 1: memory address mux; 0=PC, 1=Result.
- `memwrite` out 1: store strobe.
- `irwrite` out 1: instruction register and OldPC enable.
- `regwrite` out 1: register file write strobe.
- `resultsrc` out 2: 00=ALUOut, 01=Data, 10=ALUResult.
- `alusrca` out 2: 00=PC, 01=OldPC, 10=A (rs1), 11=zero.
- `alusrcb` out 2: 00=WriteData (rs2), 01=immext, 10=constant 4.
- `immsrc` out 3: 000 I, 001 S, 010 B, 011 U, 100 J.
- `alucontrol` out 4: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sll, 0110 srl, 0111 sra, 1000 slt, 1001 sltu.
- `illegal` out 1: high while in ILLEGAL.

## Operation
- `immsrc` is decoded combinationally from `op`:
  - I for 0000011/0010011/1100111.
  - S for 0100011.
  - B for 1100011.
  - U for 0110111/0010111.
  - J for 1101111.
  - Any other `op` gives 000.
- Per-state outputs are listed below. Outputs not listed are 0, `alucontrol` defaults to add, and selects default to 00.
  - FETCH: `irwrite`=`mem_ready`, `pcwrite`=`mem_ready`, alusrca 00, alusrcb 10, resultsrc 10. Waits while `mem_ready`=0, then goes to DECODE.
  - DECODE: alusrca 01, alusrcb 01 (branch/jal target into ALUOut). Next state by op:
    - lw/sw → MEMADR.
    - R → EXECUTER.
    - I-ALU → EXECUTEI.
    - B with funct3 ∉ {010,011} → BRANCH.
    - jal → JAL.
    - jalr with funct3=000 → JALR.
    - lui/auipc → UPPER.
    - lw requires funct3=010 and sw requires funct3=010.
    - Any other encoding → ILLEGAL.
  - MEMADR: alusrca 10, alusrcb 01. Next is MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD: adrsrc 1, resultsrc 00. Holds until `mem_ready`, then goes to MEMWB.
  - MEMWB: resultsrc 01, regwrite 1, then FETCH.
  - MEMWRITE: adrsrc 1, resultsrc 00, memwrite 1. Holds until `mem_ready`, then FETCH. `memwrite` stays high throughout the wait.
  - EXECUTER: alusrca 10, alusrcb 00, ALU op decoded from funct3/funct7b5 (sub and sra need funct7b5=1). Then ALUWB.
  - EXECUTEI: alusrca 10, alusrcb 01. Same decode, except funct7b5 is ignored for funct3=000, and funct3=101 uses funct7b5 to select srl/sra. Then ALUWB.
  - ALUWB: resultsrc 00, regwrite 1, then FETCH.
  - BRANCH: alusrca 10, alusrcb 00, sub, resultsrc 00. `pcwrite` equals the taken condition:
    - beq → zero; bne → !zero.
    - blt → lt; bge → !lt.
    - bltu → ltu; bgeu → !ltu.
    - Then FETCH.
  - JAL: alusrca 01, alusrcb 10, resultsrc 00, pcwrite 1, then ALUWB (writes OldPC+4).
  - JALR: alusrca 10, alusrcb 01, resultsrc 10, pcwrite 1, then LINK.
  - LINK: alusrca 01, alusrcb 10, then ALUWB.
  - UPPER: alusrcb 01, add. alusrca is 11 for lui and 01 for auipc. Then ALUWB.
  - ILLEGAL: all strobes 0, `illegal`=1. Sticky until reset.

## Timing
- Asynchronous reset: `rst_n` low forces state to FETCH immediately.
- While `rst_n`=0, `pcwrite`, `irwrite`, `regwrite` and `memwrite` are gated to 0. All other outputs show FETCH values; `illegal`=0.
- Instruction latencies, counting cycles with `mem_ready` always 1:
  - lw: 5.
  - sw: 4.
  - R-type and I-type: 4.
  - Branch: 3.
  - jal and lui/auipc: 4.
  - jalr: 5.
- Each cycle of `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Write strobes are single-cycle, except `memwrite`, which is held during the MEMWRITE wait.
- Outputs are combinational from state plus instruction fields. There is no registered output stage.

## Test plan
- Reset mid-MEMWRITE with `memwrite`=1: drop `rst_n` → `memwrite`=0 in the same cycle, state FETCH. After release, the first cycle has `irwrite`=1.
- `add` (op 0110011, f3 000, f7b5 0), `mem_ready`=1: FETCH→DECODE→EXECUTER (`alucontrol` 0000)→ALUWB (`regwrite`=1)→FETCH in 4 cycles. With f7b5=1, EXECUTER gives `alucontrol` 0001.
- `lw` with `mem_ready` low for 2 cycles in MEMREAD → MEMREAD lasts 3 cycles, `adrsrc`=1 throughout, then MEMWB with `resultsrc`=01 and `regwrite`=1.
- `bge`, f3 101:
  - `lt`=0 → `pcwrite`=1 in BRANCH, `immsrc`=010.
  - `lt`=1 → `pcwrite`=0.
- `jalr` (op 1100111) → JALR (`pcwrite`=1, resultsrc 10), then LINK (alusrca 01, alusrcb 10), then ALUWB. `immsrc`=000 throughout.
- op 1111111 → DECODE→ILLEGAL. `illegal`=1 and all strobes 0 for 10+ cycles, then cleared only by `rst_n`.
